// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if
//  Pipeline-side bundle for the hazard/forwarding controller.
//  master : pipeline side, drives stage addresses/controls and mem_wait,
//           receives forward selects and stall/bubble controls.
//  slave  : controller side (hazard_fwd_ctrl).
//  Signals
//   mem_wait                        external memory busy
//   id_rs_addr/id_rt_addr           ID sources; id_uses_rs/id_uses_rt/id_is_jr
//   ex_src_addr [NUM_SRC*ADDR_W]    EX operand addresses, operand k at k*ADDR_W
//   ex_dst_addr/ex_regwrite/ex_memread
//   dm_dst_addr/dm_regwrite, wb_dst_addr/wb_regwrite
//   fwd_sel [NUM_SRC*2]             10=DM, 01=WB, 00=regfile per operand
//   jr_fwd  [2]                     10=EX ALU, 01=DM, 00=regfile
//   stall_if/stall_id/bubble_ex     pipe hold and bubble controls
//   busy                            load-use stall sequence in progress
interface hazard_fwd_ctrl_if #(
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 2
);
  logic                      mem_wait;
  logic [ADDR_W-1:0]         id_rs_addr;
  logic [ADDR_W-1:0]         id_rt_addr;
  logic                      id_uses_rs;
  logic                      id_uses_rt;
  logic                      id_is_jr;
  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr;
  logic [ADDR_W-1:0]         ex_dst_addr;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic [ADDR_W-1:0]         dm_dst_addr;
  logic                      dm_regwrite;
  logic [ADDR_W-1:0]         wb_dst_addr;
  logic                      wb_regwrite;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic [1:0]                jr_fwd;
  logic                      stall_if;
  logic                      stall_id;
  logic                      bubble_ex;
  logic                      busy;

  modport master (
    output mem_wait, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_jr,
           ex_src_addr, ex_dst_addr, ex_regwrite, ex_memread,
           dm_dst_addr, dm_regwrite, wb_dst_addr, wb_regwrite,
    input  fwd_sel, jr_fwd, stall_if, stall_id, bubble_ex, busy
  );

  modport slave (
    input  mem_wait, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_jr,
           ex_src_addr, ex_dst_addr, ex_regwrite, ex_memread,
           dm_dst_addr, dm_regwrite, wb_dst_addr, wb_regwrite,
    output fwd_sel, jr_fwd, stall_if, stall_id, bubble_ex, busy
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//  Operand forwarding and hazard control for the IF/ID/EX/DM/WB pipe.
//  - per-operand EX forward selects (DM outranks WB)
//  - JR target forward select for the rs read in ID
//  - load-use stall sequence of LOAD_LAT cycles with EX bubbles
//  - freeze (stall, no bubble, state held) while mem_wait is high
//  Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; forces every output to 0
//   bus   hazard_fwd_ctrl_if.slave (stage info in, selects/stalls out)
//   stat_stall, stat_fwd  saturating 16-bit event counters, present only
//                         when HAZARD_STATS_EN is defined
//  Build option: HAZARD_STATS_EN adds the statistics counters/ports.

// One EX operand's forward select.
module hazard_fwd_lane #(
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_dm_dst,
  input  logic              i_dm_rw,
  input  logic [ADDR_W-1:0] i_wb_dst,
  input  logic              i_wb_rw,
  output logic [1:0]        o_sel
);
  logic w_dm_hit, w_wb_hit;

  assign w_dm_hit = i_dm_rw && (i_dm_dst == i_addr) && !((ZERO_REG != 0) && (i_dm_dst == '0));
  assign w_wb_hit = i_wb_rw && (i_wb_dst == i_addr) && !((ZERO_REG != 0) && (i_wb_dst == '0));
  // DM holds the younger value, so it wins over WB.
  assign o_sel    = w_dm_hit ? 2'b10 : (w_wb_hit ? 2'b01 : 2'b00);
endmodule

module hazard_fwd_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  hazard_fwd_ctrl_if.slave   bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]        stat_stall,
  output logic [15:0]        stat_fwd
`endif
);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  state_t                          r_state, w_state_nxt;
  logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
  logic [NUM_SRC-1:0][ADDR_W-1:0]  w_src;
  logic [NUM_SRC-1:0][1:0]         w_fwd;
  logic [1:0]                      w_jr;
  logic                            w_hz;
  logic                            w_stall, w_bubble;
  logic                            w_ex_rs, w_ex_rt, w_dm_rs;

  function automatic logic hit(input logic rw, input logic [ADDR_W-1:0] dst,
                               input logic [ADDR_W-1:0] a);
    return rw && (dst == a) && !((ZERO_REG != 0) && (dst == '0));
  endfunction

  // ---------------- forwarding ----------------
  assign w_src = bus.ex_src_addr;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
    hazard_fwd_lane #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_lane (
      .i_addr   (w_src[k]),
      .i_dm_dst (bus.dm_dst_addr),
      .i_dm_rw  (bus.dm_regwrite),
      .i_wb_dst (bus.wb_dst_addr),
      .i_wb_rw  (bus.wb_regwrite),
      .o_sel    (w_fwd[k])
    );
  end

  assign w_ex_rs = hit(bus.ex_regwrite, bus.ex_dst_addr, bus.id_rs_addr);
  assign w_ex_rt = hit(bus.ex_regwrite, bus.ex_dst_addr, bus.id_rt_addr);
  assign w_dm_rs = hit(bus.dm_regwrite, bus.dm_dst_addr, bus.id_rs_addr);

  // A load in EX has no result yet; the hazard path stalls it instead.
  assign w_jr = (bus.id_is_jr && w_ex_rs && !bus.ex_memread) ? 2'b10 :
                (bus.id_is_jr && w_dm_rs)                    ? 2'b01 : 2'b00;

  // JR reads rs in ID even when id_uses_rs is not flagged.
  assign w_hz = bus.ex_memread &&
                ((w_ex_rs && (bus.id_uses_rs || bus.id_is_jr)) ||
                 (w_ex_rt && bus.id_uses_rt));

  // ---------------- load-use FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    if (bus.mem_wait) begin
      // Freeze: hold everything, no bubble, regardless of hz.
      w_stall = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hz) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = LU_STALL;
              w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        LU_STALL: begin
          // hz ignored here: the sequence length is fixed by LOAD_LAT.
          w_stall   = 1'b1;
          w_bubble  = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // ---------------- outputs (all forced low during rst) ----------------
  assign bus.fwd_sel   = rst ? '0   : w_fwd;
  assign bus.jr_fwd    = rst ? 2'b0 : w_jr;
  assign bus.stall_if  = !rst && w_stall;
  assign bus.stall_id  = !rst && w_stall;
  assign bus.bubble_ex = !rst && w_bubble;
  assign bus.busy      = (r_state == LU_STALL);

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stat_stall, r_stat_fwd;
  logic        w_any_fwd;

  assign w_any_fwd = (w_fwd != '0) || (w_jr != 2'b0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stall <= '0;
      r_stat_fwd   <= '0;
    end else begin
      if (w_bubble && (r_stat_stall != 16'hFFFF))
        r_stat_stall <= r_stat_stall + 16'd1;
      if (w_any_fwd && !bus.mem_wait && (r_stat_fwd != 16'hFFFF))
        r_stat_fwd <= r_stat_fwd + 16'd1;
    end
  end

  assign stat_stall = r_stat_stall;
  assign stat_fwd   = r_stat_fwd;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
  localparam int AW = 4;
  localparam int NS = 2;
  localparam int LL = 3;
  localparam int ZR = 1;
  localparam int VW = NS*2 + 6;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  // reference state: remaining forced-stall cycles and event counts
  int   m_left;
  int   m_stall_cnt, m_fwd_cnt;

  hazard_fwd_ctrl_if #(.ADDR_W(AW), .NUM_SRC(NS)) bus();

`ifdef HAZARD_STATS_EN
  logic [15:0] stat_stall, stat_fwd;
`endif

  hazard_fwd_ctrl #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(LL), .ZERO_REG(ZR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef HAZARD_STATS_EN
    , .stat_stall (stat_stall),
    .stat_fwd   (stat_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit mt(input logic rw, input logic [AW-1:0] d, input logic [AW-1:0] a);
    return rw && (d == a) && !(ZR != 0 && d == 0);
  endfunction

  // Expected outputs from the rules: {fwd_sel, jr_fwd, stall_if, stall_id, bubble_ex, busy}
  function automatic logic [VW-1:0] exp_vec();
    logic [NS*2-1:0] f;
    logic [1:0]      j;
    logic [AW-1:0]   a;
    logic            s, b, hz;
    if (rst) return '0;
    f = '0;
    for (int k = 0; k < NS; k++) begin
      a = bus.ex_src_addr[k*AW +: AW];
      if (mt(bus.dm_regwrite, bus.dm_dst_addr, a))      f[k*2 +: 2] = 2'b10;
      else if (mt(bus.wb_regwrite, bus.wb_dst_addr, a)) f[k*2 +: 2] = 2'b01;
    end
    j = 2'b00;
    if (bus.id_is_jr && !bus.ex_memread && mt(bus.ex_regwrite, bus.ex_dst_addr, bus.id_rs_addr)) j = 2'b10;
    else if (bus.id_is_jr && mt(bus.dm_regwrite, bus.dm_dst_addr, bus.id_rs_addr))              j = 2'b01;
    hz = bus.ex_memread &&
         ((mt(bus.ex_regwrite, bus.ex_dst_addr, bus.id_rs_addr) && (bus.id_uses_rs || bus.id_is_jr)) ||
          (mt(bus.ex_regwrite, bus.ex_dst_addr, bus.id_rt_addr) && bus.id_uses_rt));
    if (bus.mem_wait)      begin s = 1; b = 0; end
    else if (m_left > 0)   begin s = 1; b = 1; end
    else if (hz)           begin s = 1; b = 1; end
    else                   begin s = 0; b = 0; end
    return {f, j, s, s, b, (m_left > 0)};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bus.fwd_sel, bus.jr_fwd, bus.stall_if, bus.stall_id, bus.bubble_ex, bus.busy};
  endfunction

  // Advance the reference by one clock using the inputs seen at the edge.
  task automatic model_clk();
    logic [VW-1:0] v;
    v = exp_vec();
    if (rst) begin
      m_left = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
    end else begin
      if (v[1] && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
      if ((v[VW-1:4] != 0) && !bus.mem_wait && m_fwd_cnt < 16'hFFFF) m_fwd_cnt++;
      if (!bus.mem_wait) begin
        if (m_left > 0)  m_left--;
        else if (v[1])   m_left = LL - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic drive_idle();
    bus.mem_wait = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0;
    bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_is_jr = 0;
    bus.ex_src_addr = '0; bus.ex_dst_addr = 0; bus.ex_regwrite = 0; bus.ex_memread = 0;
    bus.dm_dst_addr = 0; bus.dm_regwrite = 0; bus.wb_dst_addr = 0; bus.wb_regwrite = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.dm_dst_addr = 3; bus.dm_regwrite = 1; bus.ex_src_addr = {4'd3, 4'd3};
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_dst_addr = 5; bus.id_rs_addr = 5; bus.id_uses_rs = 1;
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      #4;
      checks++;
      if (obs() !== '0) begin
        errors++; $display("FAIL reset_outputs: got %b want %b", obs(), {VW{1'b0}});
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (stat_stall !== 16'd0 || stat_fwd !== 16'd0) begin
        errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_stall, stat_fwd);
      end
`endif
      tick();
    end
    drive_idle();
    rst = 0;
    tick();
  endtask

  task automatic test_fwd_priority();
    drive_idle();
    bus.dm_dst_addr = 3; bus.dm_regwrite = 1; bus.wb_dst_addr = 3; bus.wb_regwrite = 1;
    bus.ex_src_addr = {4'd9, 4'd3};
    #4;
    checks++;
    if (bus.fwd_sel[1:0] !== 2'b10 || obs() !== exp_vec()) begin
      errors++; $display("FAIL fwd_dm_over_wb: got %b want fwd0=10 vec %b", obs(), exp_vec());
    end
    tick();
    bus.dm_regwrite = 0;
    bus.wb_dst_addr = 9;  bus.dm_dst_addr = 3;
    bus.ex_src_addr = {4'd9, 4'd9};
    bus.wb_dst_addr = 3;  bus.ex_src_addr = {4'd3, 4'd3};
    #4;
    checks++;
    if (bus.fwd_sel !== 4'b0101 || obs() !== exp_vec()) begin
      errors++; $display("FAIL fwd_wb_only: got %b want 0101", bus.fwd_sel);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    drive_idle();
    bus.dm_dst_addr = 0; bus.dm_regwrite = 1; bus.wb_dst_addr = 0; bus.wb_regwrite = 1;
    bus.ex_src_addr = {4'd0, 4'd0};
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_dst_addr = 0;
    bus.id_rs_addr = 0; bus.id_uses_rs = 1; bus.id_is_jr = 1;
    #4;
    checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.stall_if !== 1'b0 || bus.jr_fwd !== 2'b00 || obs() !== exp_vec()) begin
      errors++; $display("FAIL zero_reg: got %b want all zero", obs());
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [2:0] want [4] = '{3'b110, 3'b111, 3'b111, 3'b000}; // {stall,bubble,busy}
    drive_idle();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_dst_addr = 5;
    bus.id_rs_addr = 5; bus.id_uses_rs = 1;
    for (int c = 0; c < 4; c++) begin
      #4;
      checks++;
      if ({bus.stall_if, bus.bubble_ex, bus.busy} !== want[c] || obs() !== exp_vec()) begin
        errors++; $display("FAIL load_use_c%0d: got %b want %b (vec %b)", c,
                           {bus.stall_if, bus.bubble_ex, bus.busy}, want[c], exp_vec());
      end
      tick();
      bus.ex_memread = 0; bus.ex_regwrite = 0;
    end
  endtask

  task automatic test_jr();
    drive_idle();
    bus.id_is_jr = 1; bus.id_rs_addr = 7; bus.ex_dst_addr = 7; bus.ex_regwrite = 1;
    #4;
    checks++;
    if (bus.jr_fwd !== 2'b10 || bus.stall_if !== 1'b0 || obs() !== exp_vec()) begin
      errors++; $display("FAIL jr_ex_fwd: got jr=%b stall=%b want 10/0", bus.jr_fwd, bus.stall_if);
    end
    tick();
    bus.ex_memread = 1;
    #4;
    checks++;
    if (bus.jr_fwd !== 2'b00 || bus.stall_if !== 1'b1 || obs() !== exp_vec()) begin
      errors++; $display("FAIL jr_load_stall: got jr=%b stall=%b want 00/1", bus.jr_fwd, bus.stall_if);
    end
    tick();
    for (int c = 0; c < LL - 1; c++) begin
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL jr_stall_c%0d: got %b want %b", c, obs(), exp_vec());
      end
      tick();
    end
    bus.ex_memread = 0; bus.ex_regwrite = 0; bus.dm_dst_addr = 7; bus.dm_regwrite = 1;
    #4;
    checks++;
    if (bus.jr_fwd !== 2'b01 || bus.stall_if !== 1'b0 || obs() !== exp_vec()) begin
      errors++; $display("FAIL jr_dm_fwd: got jr=%b stall=%b want 01/0", bus.jr_fwd, bus.stall_if);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [2:0] want [8] = '{3'b110, 3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b111, 3'b000};
    drive_idle();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_dst_addr = 4;
    bus.id_rt_addr = 4; bus.id_uses_rt = 1;
    for (int c = 0; c < 8; c++) begin
      bus.mem_wait = (c >= 1 && c <= 4);
      #4;
      checks++;
      if ({bus.stall_if, bus.bubble_ex, bus.busy} !== want[c] || obs() !== exp_vec()) begin
        errors++; $display("FAIL mem_wait_c%0d: got %b want %b", c,
                           {bus.stall_if, bus.bubble_ex, bus.busy}, want[c]);
      end
      tick();
      bus.ex_memread = 0; bus.ex_regwrite = 0;
    end
    bus.mem_wait = 0;
  endtask

  task automatic test_rst_mid_stall();
    drive_idle();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_dst_addr = 6;
    bus.id_rs_addr = 6; bus.id_uses_rs = 1;
    tick();
    bus.ex_memread = 0;
    #2;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL pre_rst_busy: got %b want 1", bus.busy);
    end
    rst = 1;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL rst_mid_stall: got %b want all zero", obs());
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stat_stall !== 16'd0 || stat_fwd !== 16'd0) begin
      errors++; $display("FAIL rst_mid_stats: got %0d/%0d want 0/0", stat_stall, stat_fwd);
    end
`endif
    m_left = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
    tick();
    rst = 0;
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.mem_wait    = ($urandom_range(0, 4) == 0);
      bus.id_rs_addr  = AW'($urandom_range(0, 3));
      bus.id_rt_addr  = AW'($urandom_range(0, 3));
      bus.id_uses_rs  = 1'($urandom);
      bus.id_uses_rt  = 1'($urandom);
      bus.id_is_jr    = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NS; k++) bus.ex_src_addr[k*AW +: AW] = AW'($urandom_range(0, 3));
      bus.ex_dst_addr = AW'($urandom_range(0, 3));
      bus.ex_regwrite = 1'($urandom);
      bus.ex_memread  = bus.ex_regwrite && ($urandom_range(0, 2) == 0);
      bus.dm_dst_addr = AW'($urandom_range(0, 3));
      bus.dm_regwrite = 1'($urandom);
      bus.wb_dst_addr = AW'($urandom_range(0, 3));
      bus.wb_regwrite = 1'($urandom);
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL random_c%0d: got %b want %b", c, obs(), exp_vec());
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (stat_stall !== 16'(m_stall_cnt) || stat_fwd !== 16'(m_fwd_cnt)) begin
        errors++; $display("FAIL random_stats_c%0d: got %0d/%0d want %0d/%0d", c,
                           stat_stall, stat_fwd, m_stall_cnt, m_fwd_cnt);
      end
`endif
      tick();
    end
  endtask

  initial begin
    m_left = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
    rst = 1;
    drive_idle();
    #1;
    test_reset();
    test_fwd_priority();
    test_zero_reg();
    test_load_use();
    test_jr();
    test_mem_wait();
    test_rst_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
